// File: rtl/prog_fetch.sv
// prog_fetch: instruction fetch unit with PC, 1-cycle memory read, 2-entry buffer, valid/ready output and redirect flush.
// Optional FETCH_HALT_ON_WRAP_EN: stop issuing after fetching the last address until redirect or reset.
module prog_fetch #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_w,
  input  logic [DATA_SIZE-1:0] mem_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [DATA_SIZE-1:0] instr_data,
  output logic [ADDR_SIZE-1:0] instr_pc,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE-1:0] redirect_addr,
  output logic                 halted
);
  logic [ADDR_SIZE-1:0] pc, last_addr, p0, p1;
  logic [DATA_SIZE-1:0] d0, d1;
  logic [1:0] cnt, cnt_after;
  logic inflight, pop, issue, cap;
  assign instr_valid = cnt != 2'd0;
  assign instr_data = d0;
  assign instr_pc = p0;
  assign mem_w = 1'b0;
  assign pop = instr_valid & instr_ready;
  assign cnt_after = cnt - {1'b0, pop};
  // a slot freed by this cycle's pop counts, so ready=1 sustains one word per cycle
  assign issue = en & !halted & !redirect_valid & ((cnt_after + {1'b0, inflight}) < 2'd2);
  assign cap = inflight & !redirect_valid;
  assign mem_addr = issue ? pc : last_addr;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc <= '0;
      last_addr <= '0;
      inflight <= 1'b0;
      cnt <= 2'd0;
      d0 <= '0;
      d1 <= '0;
      p0 <= '0;
      p1 <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_addr;
      inflight <= 1'b0;
      cnt <= 2'd0;
    end else begin
      inflight <= issue;
      cnt <= cnt_after + {1'b0, cap};
      if (issue) begin
        pc <= pc + 1'b1;
        last_addr <= pc;
      end
      if (pop) begin
        d0 <= d1;
        p0 <= p1;
      end
      if (cap && cnt_after == 2'd0) begin
        d0 <= mem_data;
        p0 <= last_addr;
      end else if (cap) begin
        d1 <= mem_data;
        p1 <= last_addr;
      end
    end
  end
`ifdef FETCH_HALT_ON_WRAP_EN
  logic halt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) halt_q <= 1'b0;
    else if (redirect_valid) halt_q <= 1'b0;
    else if (issue && &pc) halt_q <= 1'b1;
  end
  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_prog_fetch.sv
// tb_prog_fetch: directed scenarios plus a randomized run scored against an in-order fetch model.
module tb_prog_fetch;
  logic clk = 0, rstn = 0, en = 0, instr_ready = 0, redirect_valid = 0;
  logic [3:0] mem_addr, instr_pc, redirect_addr = 0;
  logic [15:0] mem_data = 0, instr_data;
  logic mem_w, instr_valid, halted;
  int vectors = 0, errors = 0;
`ifdef FETCH_HALT_ON_WRAP_EN
  localparam bit HALT_MODE = 1'b1;
`else
  localparam bit HALT_MODE = 1'b0;
`endif

  prog_fetch #(.DATA_SIZE(16), .ADDR_SIZE(4)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mem_addr(mem_addr), .mem_w(mem_w), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halted(halted)
  );

  always #5 clk = ~clk;
  // program memory preloaded with mem[i] = A000 + i, one-cycle registered read
  always @(posedge clk) if (!mem_w) mem_data <= 16'hA000 + {12'h0, mem_addr};

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 0; en = 0; instr_ready = 0; redirect_valid = 0; redirect_addr = 0;
    nxt(); nxt();
    rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0; en = 0; instr_ready = 0; redirect_valid = 0;
    nxt();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0 || instr_data !== 16'h0 || instr_pc !== 4'h0 || halted !== 1'b0 || mem_addr !== 4'h0 || mem_w !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h pc=%h halted=%b addr=%h w=%b expected 0 0 0 0 0 0", instr_valid, instr_data, instr_pc, halted, mem_addr, mem_w);
    end
    nxt();
    rstn = 1;
  endtask

  task automatic test_startup();
    do_reset();
    en = 1; instr_ready = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vectors++;
      if (instr_valid !== (k >= 2) || (k >= 2 && (instr_pc !== 4'(k - 2) || instr_data !== 16'hA000 + 16'(k - 2)))) begin
        errors++;
        $display("FAIL startup c%0d: valid=%b pc=%h data=%h expected valid=%b pc=%h", k, instr_valid, instr_pc, instr_data, k >= 2, 4'(k - 2));
      end
      nxt();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1; instr_ready = 0;
    nxt(); nxt(); nxt();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (instr_valid !== 1'b1 || instr_data !== 16'hA000 || instr_pc !== 4'h0 || mem_addr !== 4'h1) begin
        errors++;
        $display("FAIL backpressure hold: valid=%b data=%h pc=%h addr=%h expected 1 A000 0 1", instr_valid, instr_data, instr_pc, mem_addr);
      end
      nxt();
    end
    instr_ready = 1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      vectors++;
      if (instr_valid !== 1'b1 || instr_pc !== 4'(j) || instr_data !== 16'hA000 + 16'(j)) begin
        errors++;
        $display("FAIL backpressure release %0d: valid=%b pc=%h data=%h expected pc=%h", j, instr_valid, instr_pc, instr_data, 4'(j));
      end
      nxt();
    end
  endtask

  task automatic test_redirect();
    logic exp_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp_p [4] = '{4'h1, 4'h0, 4'h0, 4'h9};
    do_reset();
    en = 1; instr_ready = 1;
    nxt(); nxt(); nxt();
    redirect_valid = 1; redirect_addr = 4'h9;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (instr_valid !== exp_v[k] || (exp_v[k] && (instr_pc !== exp_p[k] || instr_data !== 16'hA000 + {12'h0, exp_p[k]}))) begin
        errors++;
        $display("FAIL redirect c%0d: valid=%b pc=%h data=%h expected valid=%b pc=%h", k, instr_valid, instr_pc, instr_data, exp_v[k], exp_p[k]);
      end
      if (k == 1) begin
        vectors++;
        if (mem_addr !== 4'h9) begin
          errors++;
          $display("FAIL redirect issue: mem_addr=%h expected 9", mem_addr);
        end
      end
      nxt();
      redirect_valid = 0;
    end
  endtask

  task automatic test_wrap();
    int seq;
    do_reset();
    en = 1; instr_ready = 1; redirect_valid = 1; redirect_addr = 4'hD;
    for (int k = 0; k < 10; k++) begin
      seq = 13 + k - 3;
      @(negedge clk);
      vectors++;
      if (instr_valid !== (k >= 3 && !(HALT_MODE && seq > 15)) || (instr_valid && (instr_pc !== 4'(seq) || instr_data !== 16'hA000 + 16'(seq % 16)))) begin
        errors++;
        $display("FAIL wrap c%0d: valid=%b pc=%h data=%h expected pc=%h", k, instr_valid, instr_pc, instr_data, 4'(seq));
      end
      if (k >= 6) begin
        vectors++;
        if (halted !== HALT_MODE) begin
          errors++;
          $display("FAIL wrap halted c%0d: halted=%b expected %b", k, halted, HALT_MODE);
        end
      end
      nxt();
      redirect_valid = 0;
    end
    redirect_valid = 1; redirect_addr = 4'h3;
    nxt();
    redirect_valid = 0;
    @(negedge clk);
    vectors++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap unhalt: halted=%b expected 0", halted);
    end
    nxt(); nxt();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 4'h3 || instr_data !== 16'hA003) begin
      errors++;
      $display("FAIL wrap restart: valid=%b pc=%h data=%h expected 1 3 A003", instr_valid, instr_pc, instr_data);
    end
    nxt();
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1; instr_ready = 0;
    nxt(); nxt(); nxt(); nxt();
    #2 rstn = 0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || mem_addr !== 4'h0 || instr_pc !== 4'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async reset: valid=%b addr=%h pc=%h halted=%b expected 0 0 0 0", instr_valid, mem_addr, instr_pc, halted);
    end
    nxt();
    rstn = 1; instr_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (instr_valid !== (k >= 2) || (k >= 2 && (instr_pc !== 4'(k - 2) || instr_data !== 16'hA000 + 16'(k - 2)))) begin
        errors++;
        $display("FAIL reset restart c%0d: valid=%b pc=%h data=%h", k, instr_valid, instr_pc, instr_data);
      end
      nxt();
    end
  endtask

  task automatic test_random();
    int exp_pc = 0, delivered = 0;
    bit prev_stall = 0;
    logic [15:0] pd;
    logic [3:0] pp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom % 8) != 0;
      instr_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 40) == 0;
      redirect_addr = 4'($urandom);
      @(negedge clk);
      if (prev_stall) begin
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== pp || instr_data !== pd) begin
          errors++;
          $display("FAIL random hold c%0d: valid=%b pc=%h data=%h expected 1 %h %h", c, instr_valid, instr_pc, instr_data, pp, pd);
        end
      end
      if (instr_valid && instr_ready) begin
        vectors++;
        if (instr_pc !== 4'(exp_pc) || instr_data !== 16'hA000 + 16'(exp_pc)) begin
          errors++;
          $display("FAIL random deliver c%0d: pc=%h data=%h expected pc=%h", c, instr_pc, instr_data, 4'(exp_pc));
        end
        exp_pc = (exp_pc + 1) % 16;
        delivered++;
      end
      prev_stall = instr_valid && !instr_ready && !redirect_valid;
      pp = instr_pc;
      pd = instr_data;
      if (redirect_valid) exp_pc = int'(redirect_addr);
      nxt();
    end
    redirect_valid = 0;
    vectors++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL random progress: delivered=%0d expected at least 100", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
